ctrl_pkt_gen: RTL and testbench

// - Control-path transmitter: turns one table-write request into the 3-beat AXIS control packet that

---
 rtl/ctrl_pkt_gen.sv | 183 ++++++++++++++++++
 tb/tb_ctrl_pkt_gen.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pkt_gen.sv
// ctrl_pkt_gen
//   Control-path transmitter. Each accepted table-write request becomes one
//   3-beat AXIS control packet for the stage action engines:
//     beat 1 : tdata=0, tuser[15:0]=PKT_LEN_BYTES
//     beat 2 : mod_id {stage,action} at [112+:8], CTRL_FLAG at [64+:16],
//              table index at [128+:8]
//     beat 3 : byte-swapped 16b entry at [15:0], tlast=1
//   An IDLE cycle always separates packets.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   req_valid / req_ready     request handshake
//   req_stage_id/action_id    target module id (mod_id[7:3] / mod_id[2:0])
//   req_index / req_data      table index / entry value
//   c_m_axis_*                registered AXIS master (tdata/tuser/tkeep/tvalid/tlast, tready in)
//   pkt_cnt                   16b wrapping count of completed packets
//
// Build option
//   CTRL_PKT_GEN_FIFO_EN : adds a 4-entry request FIFO ahead of the FSM so
//                          req_ready = !full regardless of FSM state.

module ctrl_pkt_gen #(
    parameter int          C_S_AXIS_DATA_WIDTH  = 256,
    parameter int          C_S_AXIS_TUSER_WIDTH = 128,
    parameter logic [15:0] CTRL_FLAG            = 16'hf2f1,
    parameter logic [15:0] PKT_LEN_BYTES        = 16'd96
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic [4:0]                           req_stage_id,
    input  logic [2:0]                           req_action_id,
    input  logic [7:0]                           req_index,
    input  logic [15:0]                          req_data,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]       c_m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]      c_m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]     c_m_axis_tkeep,
    output logic                                 c_m_axis_tvalid,
    output logic                                 c_m_axis_tlast,
    input  logic                                 c_m_axis_tready,
    output logic [15:0]                          pkt_cnt
);
    localparam int DW = C_S_AXIS_DATA_WIDTH;
    localparam int UW = C_S_AXIS_TUSER_WIDTH;
    localparam int KW = C_S_AXIS_DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, B1, B2, B3} state_e;

    state_e          state_q, state_d;
    logic [7:0]      mod_q, mod_d, idx_q, idx_d;
    logic [15:0]     data_q, data_d;
    logic [15:0]     pkt_cnt_q, pkt_cnt_d;
    logic [DW-1:0]   tdata_q, tdata_d;
    logic [UW-1:0]   tuser_q, tuser_d;
    logic [KW-1:0]   tkeep_q, tkeep_d;
    logic            tvalid_q, tvalid_d, tlast_q, tlast_d;

    // Request presented to the FSM in IDLE: {mod_id, index, data}
    logic            start;
    logic [31:0]     src;
    logic [31:0]     req_ent;
    logic            xfer;

    assign req_ent = {req_stage_id, req_action_id, req_index, req_data};
    assign xfer    = tvalid_q & c_m_axis_tready;

`ifdef CTRL_PKT_GEN_FIFO_EN
    logic [31:0] mem_q [4];
    logic [1:0]  wr_ptr_q, rd_ptr_q;
    logic [2:0]  cnt_q;
    logic        empty, full, pop, bypass, push;

    assign empty     = (cnt_q == 3'd0);
    assign full      = (cnt_q == 3'd4);
    assign req_ready = !full;
    assign pop       = (state_q == IDLE) && !empty;
    // Empty FIFO + idle FSM: hand the request straight over, no storage.
    assign bypass    = (state_q == IDLE) && empty && req_valid;
    assign push      = req_valid && req_ready && !bypass;
    assign start     = pop || bypass;
    assign src       = pop ? mem_q[rd_ptr_q] : req_ent;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            cnt_q    <= 3'd0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
            if (push && !pop)      cnt_q <= cnt_q + 3'd1;
            else if (pop && !push) cnt_q <= cnt_q - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= req_ent;
    end
`else
    assign req_ready = (state_q == IDLE);
    assign start     = (state_q == IDLE) && req_valid;
    assign src       = req_ent;
`endif

    always_comb begin
        state_d   = state_q;
        mod_d     = mod_q;
        idx_d     = idx_q;
        data_d    = data_q;
        pkt_cnt_d = pkt_cnt_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = B1;
                mod_d   = src[31:24];
                idx_d   = src[23:16];
                data_d  = src[15:0];
            end
            B1: if (xfer) state_d = B2;
            B2: if (xfer) state_d = B3;
            B3: if (xfer) begin
                state_d   = IDLE;
                pkt_cnt_d = pkt_cnt_q + 16'd1;
            end
            default: state_d = IDLE;
        endcase

        // Output registers load the beat of the *next* state; during a stall
        // state_d == state_q and the fields are unchanged, so the beat holds.
        tvalid_d = (state_d != IDLE);
        tkeep_d  = tvalid_d ? {KW{1'b1}} : {KW{1'b0}};
        tlast_d  = (state_d == B3);
        tdata_d  = '0;
        tuser_d  = '0;
        case (state_d)
            B1: tuser_d[15:0] = PKT_LEN_BYTES;
            B2: begin
                tdata_d[112 +: 8] = mod_d;
                tdata_d[64 +: 16] = CTRL_FLAG;
                tdata_d[128 +: 8] = idx_d;
            end
            B3: begin
                tdata_d[7:0]  = data_d[15:8];
                tdata_d[15:8] = data_d[7:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mod_q     <= 8'd0;
            idx_q     <= 8'd0;
            data_q    <= 16'd0;
            pkt_cnt_q <= 16'd0;
            tdata_q   <= '0;
            tuser_q   <= '0;
            tkeep_q   <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            mod_q     <= mod_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            pkt_cnt_q <= pkt_cnt_d;
            tdata_q   <= tdata_d;
            tuser_q   <= tuser_d;
            tkeep_q   <= tkeep_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
        end
    end

    assign c_m_axis_tdata  = tdata_q;
    assign c_m_axis_tuser  = tuser_q;
    assign c_m_axis_tkeep  = tkeep_q;
    assign c_m_axis_tvalid = tvalid_q;
    assign c_m_axis_tlast  = tlast_q;
    assign pkt_cnt         = pkt_cnt_q;

endmodule

// File: tb/tb_ctrl_pkt_gen.sv
// Bench for ctrl_pkt_gen: directed scenarios plus randomized traffic, checked
// against a beat-queue reference model built from the packet format rules.
module tb_ctrl_pkt_gen;
  logic         clk = 0, rst = 1;
  logic         req_valid = 0, req_ready;
  logic [4:0]   req_stage_id = 0;
  logic [2:0]   req_action_id = 0;
  logic [7:0]   req_index = 0;
  logic [15:0]  req_data = 0;
  logic [255:0] tdata;
  logic [127:0] tuser;
  logic [31:0]  tkeep;
  logic         tvalid, tlast, tready = 0;
  logic [15:0]  pkt_cnt;

  ctrl_pkt_gen dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_stage_id(req_stage_id), .req_action_id(req_action_id),
    .req_index(req_index), .req_data(req_data),
    .c_m_axis_tdata(tdata), .c_m_axis_tuser(tuser), .c_m_axis_tkeep(tkeep),
    .c_m_axis_tvalid(tvalid), .c_m_axis_tlast(tlast),
    .c_m_axis_tready(tready), .pkt_cnt(pkt_cnt));

  typedef struct { logic [255:0] d; logic [127:0] u; logic last; } beat_t;

  int compared = 0, mismatched = 0;
  int cyc = 0, tr_mode = 0, beat_idx = 0;
  bit mon_en = 0;
  beat_t exp_q[$];
  logic [255:0] seen[$];
  int starts[$];
  logic [15:0] model_cnt = 0;

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Packet contents derived directly from the format rules.
  task automatic push_pkt(input logic [4:0] s, input logic [2:0] a, input logic [7:0] i, input logic [15:0] d);
    beat_t b;
    b.d = '0; b.u = 128'd96; b.last = 0; exp_q.push_back(b);
    b.d = (256'(16'hf2f1) << 64) | (256'({s, a}) << 112) | (256'(i) << 128);
    b.u = '0; exp_q.push_back(b);
    b.d = 256'({d[7:0], d[15:8]}); b.last = 1; exp_q.push_back(b);
  endtask

  // tready driver
  initial forever begin
    @(posedge clk); #1;
    case (tr_mode)
      0: tready = 1;
      1: tready = !tready;
      2: tready = 1'($urandom_range(0, 1));
      default: tready = 0;
    endcase
  end

  // Monitor / scoreboard, sampled mid-cycle
  initial begin
    logic [255:0] pd; logic [127:0] pu; logic pl;
    bit stall_prev = 0, prev_tvalid = 0;
    beat_t b;
    pd = '0; pu = '0; pl = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (rst) begin
          exp_q.delete(); model_cnt = 0; beat_idx = 0; stall_prev = 0;
        end else begin
          check("pkt_cnt", 256'(pkt_cnt), 256'(model_cnt));
          if (stall_prev) begin
            check("stall_valid", 256'(tvalid), 256'(1));
            check("stall_data", tdata, pd);
            check("stall_user", 256'(tuser), 256'(pu));
            check("stall_last", 256'(tlast), 256'(pl));
          end
          if (tvalid && !prev_tvalid) starts.push_back(cyc);
          if (tvalid && tready) begin
            check("beat_expected", 256'(exp_q.size() != 0), 256'(1));
            if (exp_q.size() != 0) begin
              b = exp_q.pop_front();
              check("tdata", tdata, b.d);
              check("tuser", 256'(tuser), 256'(b.u));
              check("tkeep", 256'(tkeep), 256'(32'hffffffff));
              check("tlast", 256'(tlast), 256'(b.last));
            end
            seen.push_back(tdata);
            if (tlast) begin model_cnt++; beat_idx = 0; end
            else beat_idx++;
          end
          if (req_valid && req_ready) push_pkt(req_stage_id, req_action_id, req_index, req_data);
          stall_prev = tvalid && !tready;
          pd = tdata; pu = tuser; pl = tlast;
        end
        prev_tvalid = tvalid;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] s, input logic [2:0] a, input logic [7:0] i, input logic [15:0] d);
    int n = 0; bit ok = 0;
    req_stage_id = s; req_action_id = a; req_index = i; req_data = d; req_valid = 1;
    while (!ok && n < 300) begin @(negedge clk); ok = req_ready; n++; end
    check("accept_in_time", 256'(ok), 256'(1));
    @(posedge clk); #1;
    req_valid = 0;
    // Scramble inputs: the latched request must not follow them.
    req_stage_id = 5'($urandom); req_action_id = 3'($urandom);
    req_index = 8'($urandom); req_data = 16'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0; bit done = 0;
    while (!done && n < 2000) begin
      @(negedge clk); n++;
      done = (exp_q.size() == 0) && !tvalid;
    end
    check("drain_in_time", 256'(done), 256'(1));
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    rst = 1; tr_mode = 0;
    tick(2);
    @(negedge clk);
    check("rst_tvalid", 256'(tvalid), 256'(0));
    check("rst_tdata", tdata, 256'(0));
    check("rst_tuser", 256'(tuser), 256'(0));
    check("rst_tkeep", 256'(tkeep), 256'(0));
    check("rst_tlast", 256'(tlast), 256'(0));
    check("rst_ready", 256'(req_ready), 256'(1));
    check("rst_cnt", 256'(pkt_cnt), 256'(0));
    @(posedge clk); #1;
    rst = 0; mon_en = 1;

    // Single request
    seen.delete();
    issue(5'd2, 3'd3, 8'h05, 16'hbeef);
    wait_idle();
    check("single_beats", 256'(seen.size()), 256'(3));
    if (seen.size() == 3) begin
      check("b2_modid", 256'(seen[1][112 +: 8]), 256'(8'h13));
      check("b2_flag", 256'(seen[1][64 +: 16]), 256'(16'hf2f1));
      check("b2_index", 256'(seen[1][128 +: 8]), 256'(8'h05));
      check("b3_data", 256'(seen[2][15:0]), 256'(16'hefbe));
    end
    check("single_cnt", 256'(pkt_cnt), 256'(1));

    // tready toggling across a packet
    tr_mode = 1; seen.delete();
    issue(5'd17, 3'd6, 8'ha5, 16'h1234);
    wait_idle();
    check("toggle_beats", 256'(seen.size()), 256'(3));
    tr_mode = 0; tick(1);

    // Back-to-back requests
    starts.delete();
    issue(5'd1, 3'd1, 8'h11, 16'h0102);
`ifndef CTRL_PKT_GEN_FIFO_EN
    @(negedge clk);
    check("busy_ready", 256'(req_ready), 256'(0));
    @(posedge clk); #1;
`endif
    issue(5'd31, 3'd7, 8'hff, 16'hfffe);
    wait_idle();
    check("b2b_starts", 256'(starts.size()), 256'(2));
    if (starts.size() >= 2) check("b2b_spacing", 256'(starts[1] - starts[0]), 256'(4));

    // Reset while in beat 2
    issue(5'd4, 3'd2, 8'h33, 16'h5555);
    tick(1);           // now showing beat 2
    rst = 1;
    tick(1);
    rst = 0;
    @(negedge clk);
    check("rstB2_tvalid", 256'(tvalid), 256'(0));
    check("rstB2_ready", 256'(req_ready), 256'(1));
    check("rstB2_cnt", 256'(pkt_cnt), 256'(0));
    @(posedge clk); #1;
    seen.delete();
    issue(5'd9, 3'd5, 8'h42, 16'hcafe);
    wait_idle();
    check("post_rst_beats", 256'(seen.size()), 256'(3));

    // Counter wrap
    force dut.pkt_cnt_q = 16'hfffe;
    model_cnt = 16'hfffe;
    tick(2);
    release dut.pkt_cnt_q;
    tick(1);
    issue(5'd0, 3'd0, 8'h00, 16'h0000);
    wait_idle();
    check("wrap_ffff", 256'(pkt_cnt), 256'(16'hffff));
    issue(5'd3, 3'd4, 8'h77, 16'h8001);
    wait_idle();
    check("wrap_0000", 256'(pkt_cnt), 256'(0));

`ifdef CTRL_PKT_GEN_FIFO_EN
    // FIFO fill under back-pressure: one request goes straight into the
    // (stalled) FSM, four more fill the FIFO, then ready drops.
    tr_mode = 3; tick(2);
    for (int k = 0; k < 5; k++) issue(5'(k + 1), 3'(k), 8'(8'h10 + k), 16'(16'h1000 + k));
    @(negedge clk);
    check("fifo_full_ready", 256'(req_ready), 256'(0));
    @(posedge clk); #1;
    tr_mode = 0;
    issue(5'd20, 3'd5, 8'h99, 16'h6006);
    wait_idle();
`endif

    // Randomized traffic under random back-pressure
    tr_mode = 2;
    for (int k = 0; k < 40; k++) begin
      issue(5'($urandom), 3'($urandom), 8'($urandom), 16'($urandom));
      tick($urandom_range(0, 5));
    end
    tr_mode = 0;
    wait_idle();
    check("all_beats_seen", 256'(exp_q.size()), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: sim did not finish");
    $fatal(1, "timeout");
  end
endmodule
